// File: rtl/telem_rcv.sv
// Telemetry receiver: 8N1 UART deserializer plus 8-byte packet framer (AA 55 BATT CURR TORQUE).
// Optional idle timeout on partial packets when TELEM_TIMEOUT_EN is defined.
module telem_rcv #(
  parameter int unsigned BAUD_DIV = 2604,
  parameter logic [7:0]  HDR0     = 8'hAA,
  parameter logic [7:0]  HDR1     = 8'h55
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic [11:0] batt,
  output logic [11:0] curr,
  output logic [11:0] torque,
  output logic        vld,
  output logic        frm_err,
  output logic        pkt_err,
  output logic [15:0] pkt_cnt
);

  // Counter reloads are one less than the interval, since the action happens on count 0.
  localparam logic [11:0] BitLd  = 12'(BAUD_DIV - 1);
  localparam logic [11:0] HalfLd = 12'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {BitIdle, BitStart, BitData, BitStop} bit_st_e;
  typedef enum logic [1:0] {PktHunt0, PktHunt1, PktPayload} pkt_st_e;

  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  bit_st_e     bit_st_q, bit_st_d;
  logic [11:0] baud_q, baud_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        byte_rdy_q, byte_rdy_d;
  logic        frm_err_q, frm_err_d;

  pkt_st_e     pkt_st_q, pkt_st_d;
  logic [2:0]  idx_q, idx_d;
  logic [11:0] sh_batt_q, sh_batt_d;
  logic [11:0] sh_curr_q, sh_curr_d;
  logic [3:0]  sh_thi_q, sh_thi_d;
  logic [11:0] batt_q, batt_d, curr_q, curr_d, torque_q, torque_d;
  logic        vld_q, vld_d, pkt_err_q, pkt_err_d;
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic        to_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  always_comb begin
    bit_st_d   = bit_st_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    byte_rdy_d = 1'b0;
    frm_err_d  = 1'b0;
    unique case (bit_st_q)
      BitIdle: begin
        if (rx_prev_q && !rx_sync_q) begin
          bit_st_d = BitStart;
          baud_d   = HalfLd;
        end
      end
      BitStart: begin
        if (baud_q == 12'd0) begin
          if (rx_sync_q) begin
            bit_st_d = BitIdle;
          end else begin
            bit_st_d  = BitData;
            baud_d    = BitLd;
            bit_idx_d = 3'd0;
          end
        end else begin
          baud_d = baud_q - 12'd1;
        end
      end
      BitData: begin
        if (baud_q == 12'd0) begin
          shreg_d   = {rx_sync_q, shreg_q[7:1]};
          baud_d    = BitLd;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) bit_st_d = BitStop;
        end else begin
          baud_d = baud_q - 12'd1;
        end
      end
      BitStop: begin
        if (baud_q == 12'd0) begin
          byte_rdy_d = rx_sync_q;
          frm_err_d  = !rx_sync_q;
          bit_st_d   = BitIdle;
        end else begin
          baud_d = baud_q - 12'd1;
        end
      end
      default: bit_st_d = BitIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_st_q   <= BitIdle;
      baud_q     <= 12'd0;
      bit_idx_q  <= 3'd0;
      shreg_q    <= 8'd0;
      byte_rdy_q <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      bit_st_q   <= bit_st_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      byte_rdy_q <= byte_rdy_d;
      frm_err_q  <= frm_err_d;
    end
  end

`ifdef TELEM_TIMEOUT_EN
  localparam logic [19:0] ToLimit = 20'(12 * BAUD_DIV);
  logic [19:0] to_cnt_q;

  assign to_hit = (pkt_st_q != PktHunt0) && (to_cnt_q == ToLimit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= 20'd0;
    end else if (pkt_st_q == PktHunt0 || byte_rdy_q || to_hit) begin
      to_cnt_q <= 20'd0;
    end else begin
      to_cnt_q <= to_cnt_q + 20'd1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  // shreg_q still holds the completed byte in the cycle byte_rdy_q is high.
  always_comb begin
    pkt_st_d  = pkt_st_q;
    idx_d     = idx_q;
    sh_batt_d = sh_batt_q;
    sh_curr_d = sh_curr_q;
    sh_thi_d  = sh_thi_q;
    batt_d    = batt_q;
    curr_d    = curr_q;
    torque_d  = torque_q;
    vld_d     = 1'b0;
    pkt_err_d = 1'b0;
    pkt_cnt_d = pkt_cnt_q;
    if (frm_err_q) begin
      pkt_st_d = PktHunt0;
    end else if (to_hit) begin
      pkt_err_d = 1'b1;
      pkt_st_d  = PktHunt0;
    end else if (byte_rdy_q) begin
      unique case (pkt_st_q)
        PktHunt0: if (shreg_q == HDR0) pkt_st_d = PktHunt1;
        PktHunt1: begin
          if (shreg_q == HDR1) begin
            pkt_st_d = PktPayload;
            idx_d    = 3'd0;
          end else if (shreg_q != HDR0) begin
            pkt_st_d = PktHunt0;
          end
        end
        PktPayload: begin
          if (!idx_q[0] && shreg_q[7:4] != 4'd0) begin
            pkt_err_d = 1'b1;
            pkt_st_d  = PktHunt0;
          end else begin
            idx_d = idx_q + 3'd1;
            case (idx_q)
              3'd0: sh_batt_d[11:8] = shreg_q[3:0];
              3'd1: sh_batt_d[7:0]  = shreg_q;
              3'd2: sh_curr_d[11:8] = shreg_q[3:0];
              3'd3: sh_curr_d[7:0]  = shreg_q;
              3'd4: sh_thi_d        = shreg_q[3:0];
              default: begin
                batt_d    = sh_batt_q;
                curr_d    = sh_curr_q;
                torque_d  = {sh_thi_q, shreg_q};
                vld_d     = 1'b1;
                pkt_cnt_d = pkt_cnt_q + 16'd1;
                pkt_st_d  = PktHunt0;
              end
            endcase
          end
        end
        default: pkt_st_d = PktHunt0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_st_q  <= PktHunt0;
      idx_q     <= 3'd0;
      sh_batt_q <= 12'd0;
      sh_curr_q <= 12'd0;
      sh_thi_q  <= 4'd0;
      batt_q    <= 12'd0;
      curr_q    <= 12'd0;
      torque_q  <= 12'd0;
      vld_q     <= 1'b0;
      pkt_err_q <= 1'b0;
      pkt_cnt_q <= 16'd0;
    end else begin
      pkt_st_q  <= pkt_st_d;
      idx_q     <= idx_d;
      sh_batt_q <= sh_batt_d;
      sh_curr_q <= sh_curr_d;
      sh_thi_q  <= sh_thi_d;
      batt_q    <= batt_d;
      curr_q    <= curr_d;
      torque_q  <= torque_d;
      vld_q     <= vld_d;
      pkt_err_q <= pkt_err_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign batt    = batt_q;
  assign curr    = curr_q;
  assign torque  = torque_q;
  assign vld     = vld_q;
  assign frm_err = frm_err_q;
  assign pkt_err = pkt_err_q;
  assign pkt_cnt = pkt_cnt_q;

endmodule

// File: tb/tb_telem_rcv.sv
// Self-checking bench for telem_rcv: directed plan cases plus randomized packets against a
// byte-stream reference model. Timeout expectations follow TELEM_TIMEOUT_EN.
module tb_telem_rcv;

  localparam int unsigned Baud = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic [11:0] batt, curr, torque;
  logic        vld, frm_err, pkt_err;
  logic [15:0] pkt_cnt;

  telem_rcv #(.BAUD_DIV(Baud)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (RX),
    .batt    (batt),
    .curr    (curr),
    .torque  (torque),
    .vld     (vld),
    .frm_err (frm_err),
    .pkt_err (pkt_err),
    .pkt_cnt (pkt_cnt)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Pulse counters seen by the monitor (cumulative over the whole run).
  int seen_vld = 0, seen_perr = 0, seen_ferr = 0, seen_both = 0;

  always @(negedge clk) begin
    if (vld) seen_vld++;
    if (pkt_err) seen_perr++;
    if (frm_err) seen_ferr++;
    if (vld && pkt_err) seen_both++;
  end

  // Reference model: position in the packet (0 hunt AA, 1 hunt 55, 2..7 payload byte k-2).
  int         m_ph = 0;
  logic [7:0] m_pay [6];
  int         exp_vld = 0, exp_perr = 0, exp_ferr = 0;
  logic [11:0] exp_batt = 0, exp_curr = 0, exp_torque = 0;
  logic [15:0] exp_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_byte(input logic [7:0] b, input bit stop_ok);
    int k;
    if (!stop_ok) begin
      exp_ferr++;
      m_ph = 0;
    end else if (m_ph == 0) begin
      if (b == 8'hAA) m_ph = 1;
    end else if (m_ph == 1) begin
      if (b == 8'h55) m_ph = 2;
      else if (b != 8'hAA) m_ph = 0;
    end else begin
      k = m_ph - 2;
      if ((k % 2) == 0 && b[7:4] != 4'd0) begin
        exp_perr++;
        m_ph = 0;
      end else begin
        m_pay[k] = b;
        if (k == 5) begin
          exp_batt   = {m_pay[0][3:0], m_pay[1]};
          exp_curr   = {m_pay[2][3:0], m_pay[3]};
          exp_torque = {m_pay[4][3:0], m_pay[5]};
          exp_vld++;
          exp_cnt++;
          m_ph = 0;
        end else begin
          m_ph++;
        end
      end
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
    @(negedge clk);
    RX = 1'b0;
    repeat (Baud) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (Baud) @(negedge clk);
    end
    RX = stop_ok;
    repeat (Baud) @(negedge clk);
    RX = 1'b1;
    if (!stop_ok) repeat (Baud) @(negedge clk);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    model_byte(b, stop_ok);
  endtask

  task automatic send_pkt(input logic [11:0] b, input logic [11:0] c, input logic [11:0] t);
    send_byte(8'hAA);
    send_byte(8'h55);
    send_byte({4'd0, b[11:8]});
    send_byte(b[7:0]);
    send_byte({4'd0, c[11:8]});
    send_byte(c[7:0]);
    send_byte({4'd0, t[11:8]});
    send_byte(t[7:0]);
  endtask

  task automatic check_all(input string tag);
    repeat (4) @(negedge clk);
    check({tag, ".vld_cnt"}, seen_vld, exp_vld);
    check({tag, ".perr_cnt"}, seen_perr, exp_perr);
    check({tag, ".ferr_cnt"}, seen_ferr, exp_ferr);
    check({tag, ".batt"}, 32'(batt), 32'(exp_batt));
    check({tag, ".curr"}, 32'(curr), 32'(exp_curr));
    check({tag, ".torque"}, 32'(torque), 32'(exp_torque));
    check({tag, ".pkt_cnt"}, 32'(pkt_cnt), 32'(exp_cnt));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".batt0"}, 32'(batt), 0);
    check({tag, ".curr0"}, 32'(curr), 0);
    check({tag, ".torque0"}, 32'(torque), 0);
    check({tag, ".flags0"}, {29'd0, vld, frm_err, pkt_err}, 0);
    check({tag, ".pkt_cnt0"}, 32'(pkt_cnt), 0);
  endtask

  initial begin
    logic [7:0] bytes [8];
    int mode, pos;

    repeat (5) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Good packet from the plan, with fixed expected fields.
    send_pkt(12'hB11, 12'h123, 12'h700);
    check_all("good");
    check("good.batt_const", 32'(batt), 32'hB11);
    check("good.torque_const", 32'(torque), 32'h700);
    check("good.cnt_const", 32'(pkt_cnt), 1);

    // Resync on junk and repeated header bytes.
    send_byte(8'h13);
    send_byte(8'hAA);
    send_pkt(12'h4A5, 12'hFFF, 12'h001);
    check_all("resync");

    // Bad hi nibble on the first payload byte, then a good packet.
    send_byte(8'hAA);
    send_byte(8'h55);
    send_byte(8'h1B);
    send_byte(8'h11);
    check_all("nibble");
    send_pkt(12'h0F0, 12'h321, 12'h9AB);
    check_all("nibble_next");

    // Stop bit low on the 4th byte, then a good packet.
    send_byte(8'hAA);
    send_byte(8'h55);
    send_byte(8'h02);
    send_byte(8'h34, 1'b0);
    check_all("frame");
    send_pkt(12'h5C3, 12'h0AA, 12'hE07);
    check_all("frame_next");

    // Short low glitch must be rejected at the start-bit re-sample.
    @(negedge clk);
    RX = 1'b0;
    repeat (Baud / 4) @(negedge clk);
    RX = 1'b1;
    repeat (3 * Baud) @(negedge clk);
    check_all("glitch");

    // Randomized packets: good, bad nibble, framing error, or leading junk.
    for (int n = 0; n < 24; n++) begin
      mode = $urandom_range(0, 3);
      bytes[0] = 8'hAA;
      bytes[1] = 8'h55;
      for (int j = 2; j < 8; j++) bytes[j] = (j % 2 == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      pos = $urandom_range(2, 7);
      if (mode == 1) bytes[pos & 6] = {4'($urandom_range(1, 15)), 4'($urandom)};
      if (mode == 3) repeat ($urandom_range(1, 3)) send_byte(8'($urandom));
      for (int j = 0; j < 8; j++) send_byte(bytes[j], !(mode == 2 && j == pos));
      check_all("rand");
    end

    // Reset in the middle of a payload byte clears everything.
    send_byte(8'hAA);
    send_byte(8'h55);
    send_byte(8'h0B);
    @(negedge clk);
    RX = 1'b0;
    repeat (3 * Baud) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("midrst");
    RX = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    m_ph = 0;
    exp_batt = 0;
    exp_curr = 0;
    exp_torque = 0;
    exp_cnt = 0;
    repeat (2 * Baud) @(negedge clk);
    send_pkt(12'h777, 12'h888, 12'h999);
    check_all("after_rst");
    check("after_rst.cnt_const", 32'(pkt_cnt), 1);

    // Stalled partial packet: timeout build aborts it, default build keeps framing.
    send_byte(8'hAA);
    send_byte(8'h55);
    send_byte(8'h0B);
    repeat (12 * Baud + 10) @(negedge clk);
`ifdef TELEM_TIMEOUT_EN
    exp_perr++;
    m_ph = 0;
`endif
    check_all("stall");
    send_pkt(12'h246, 12'h8AC, 12'h135);
    check_all("stall_next");

    check("vld_perr_excl", seen_both, 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #3000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/telem_rcv.md
Name: telem_rcv

Overview:
- Downstream consumer of the eBike TX telemetry line: a bench-side and reusable telemetry monitor.
- Deserializes 8N1 UART bytes and frames 8-byte packets (0xAA, 0x55, BATT hi/lo, CURR hi/lo, TORQUE hi/lo).
- Presents 12-bit BATT/CURR/TORQUE with a one-cycle valid strobe, so self-checking benches can compare telemetry against the analog stimulus.

Parameters:
- BAUD_DIV, 2604: clk cycles per bit (50 MHz / 19200 baud); legal range 16..4095.
- HDR0, 8'hAA: first header byte.
- HDR1, 8'h55: second header byte.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- RX  input  1  serial telemetry line, idle high, asynchronous to clk
- batt  output  12  last good packet BATT field
- curr  output  12  last good packet CURR field
- torque  output  12  last good packet TORQUE field
- vld  output  1  one-clk pulse when a complete good packet is latched
- frm_err  output  1  one-clk pulse on a byte with stop bit sampled low
- pkt_err  output  1  one-clk pulse on a packet aborted (bad hi-nibble or timeout)
- pkt_cnt  output  16  count of good packets, wraps 16'hFFFF->0

Behaviour:
- Reset (async, rst_n low): all outputs 0; RX synchronizer flops preset to 1; both FSMs reset to idle/HUNT0.
- RX passes a 2-flop synchronizer (preset high) before any use.
- Bit FSM states are IDLE, START, DATA, STOP:
  - IDLE->START on synced falling edge; baud counter loads BAUD_DIV/2.
  - In START, at count 0 re-sample: if high (glitch) ->IDLE; else load BAUD_DIV ->DATA.
  - DATA samples 8 bits LSB first at mid-bit, then ->STOP.
  - STOP samples at mid-bit: high gives byte_rdy (internal 1-clk pulse); low gives frm_err pulse, byte discarded.
  - Both STOP outcomes return to IDLE immediately after the stop sample (no wait for bit end).
- Byte latency: byte_rdy asserts at mid-stop-bit, 9.5*BAUD_DIV (+3 sync) clk after the start edge.
- Packet FSM states are HUNT0, HUNT1, PAYLOAD (index 0..5):
  - HUNT0: byte==HDR0 ->HUNT1; otherwise stay.
  - HUNT1: byte==HDR1 ->PAYLOAD idx0; byte==HDR0 stay HUNT1; other ->HUNT0.
  - PAYLOAD: even idx (hi byte) must have bits[7:4]==0, else pkt_err pulse ->HUNT0 with shadow regs discarded.
  - Bytes go to shadow regs {hi[3:0],lo}; after idx5 accepted, batt/curr/torque update from shadow and vld pulses in the same clk (1 clk after byte_rdy). pkt_cnt increments that clk. FSM ->HUNT0.
  - frm_err during PAYLOAD or HUNT1 aborts to HUNT0 without pkt_err.
- Outputs hold last good values between packets; partial packets never alter them.
- Simultaneous events: frm_err takes priority over packet advancement. vld and pkt_err are mutually exclusive.
- rst_n asserted mid-byte or mid-packet: everything clears. The first byte after release must begin with a fresh start edge on an idle-high line.

Optional Feature:
- Macro: TELEM_TIMEOUT_EN.
- Defined: a 20-bit idle counter runs while the packet FSM is in HUNT1 or PAYLOAD and clears on each byte_rdy. At 12*BAUD_DIV clk with no byte, it fires a pkt_err pulse and ->HUNT0.
- Undefined: no counter; a stalled partial packet waits indefinitely and the next bytes continue framing.

Test Plan:
- Good packet: send AA 55 0B 11 01 23 07 00 at BAUD_DIV=16 -> batt=12'hB11, curr=12'h123, torque=12'h700; one vld pulse; pkt_cnt=1.
- Resync: send 13 AA AA 55 then a valid payload -> single vld with correct fields; no pkt_err.
- Bad nibble: AA 55 1B ... -> pkt_err pulse at the third byte, outputs unchanged, no vld. The next good packet is accepted.
- Framing error: hold stop bit low on the 4th byte -> frm_err pulse, no vld; the following full packet gives vld.
- Glitch: RX low for BAUD_DIV/4 clk -> no byte_rdy, no errors. Reset asserted mid-payload -> all outputs 0; the next good packet gives pkt_cnt=1.
- With TELEM_TIMEOUT_EN: send AA 55 0B then idle 12*BAUD_DIV+10 clk -> pkt_err pulse; without the macro, no pulse.
